// File: rtl/tc_div_29s_12ns_17s_seq.sv
// Sequential signed/unsigned divider: 29-bit two's-complement dividend by 12-bit unsigned divisor,
// restoring algorithm one bit per cycle, saturating 17-bit quotient, remainder takes the dividend sign.
module tc_div_29s_12ns_17s_seq #(
   parameter int DIVIDEND_W = 29,
   parameter int DIVISOR_W  = 12,
   parameter int QUOT_W     = 17
) (
   input  logic                           ap_clk,
   input  logic                           ap_rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [DIVIDEND_W-1:0]   dividend,
   input  logic        [DIVISOR_W-1:0]    divisor,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [QUOT_W-1:0]       quotient,
   output logic signed [DIVISOR_W:0]      remainder,
   output logic                           ovf,
   output logic                           dbz
);

   localparam int CNT_W = $clog2(DIVIDEND_W);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
   localparam logic [QUOT_W-1:0]     QMAX     = {1'b0, {(QUOT_W-1){1'b1}}};
   localparam logic [QUOT_W-1:0]     QMIN     = {1'b1, {(QUOT_W-1){1'b0}}};
   localparam logic [DIVIDEND_W-1:0] POS_LIM  = {{(DIVIDEND_W-QUOT_W){1'b0}}, QMAX};
   localparam logic [DIVIDEND_W-1:0] NEG_LIM  = {{(DIVIDEND_W-QUOT_W){1'b0}}, QMIN};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state_q, state_d;

   // Returns {ovf, quotient}; a negative magnitude of exactly 2^(QUOT_W-1) is representable.
   function automatic logic [QUOT_W:0] sat_quot(input logic [DIVIDEND_W-1:0] mag, input logic neg);
      logic [QUOT_W-1:0] lo;
      lo = mag[QUOT_W-1:0];
      if (neg) begin
         if (mag > NEG_LIM) return {1'b1, QMIN};
         return {1'b0, QUOT_W'(~lo + 1'b1)};
      end
      if (mag > POS_LIM) return {1'b1, QMAX};
      return {1'b0, lo};
   endfunction

   function automatic logic [DIVISOR_W:0] sign_rem(input logic [DIVISOR_W-1:0] mag, input logic neg);
      logic [DIVISOR_W:0] ext;
      ext = {1'b0, mag};
      return neg ? (DIVISOR_W+1)'(~ext + 1'b1) : ext;
   endfunction

   logic [CNT_W-1:0]      cnt_q;
   logic [DIVIDEND_W-1:0] dvd_q;
   logic [DIVISOR_W-1:0]  rem_q, div_q;
   logic                  neg_q;
   logic [QUOT_W-1:0]     q_fix_q;
   logic [DIVISOR_W:0]    r_fix_q;
   logic                  ovf_fix_q, dbz_fix_q;
   logic                  out_valid_q, ovf_q, dbz_q;
   logic [QUOT_W-1:0]     quot_q;
   logic [DIVISOR_W:0]    rem_out_q;

   logic                  accept;
   logic [DIVIDEND_W-1:0] abs_in;
   logic [DIVISOR_W:0]    trial;
   logic                  qbit;
   logic [DIVISOR_W-1:0]  rem_d;
   logic [QUOT_W:0]       sat;

   assign in_ready  = (state_q == IDLE) && ap_rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign quotient  = quot_q;
   assign remainder = rem_out_q;
   assign ovf       = ovf_q;
   assign dbz       = dbz_q;

   always_comb begin
      abs_in = dividend[DIVIDEND_W-1] ? $unsigned(~dividend + 1'b1) : $unsigned(dividend);
      trial  = {rem_q, dvd_q[DIVIDEND_W-1]};
      qbit   = (trial >= {1'b0, div_q});
      rem_d  = qbit ? DIVISOR_W'(trial - {1'b0, div_q}) : trial[DIVISOR_W-1:0];
      sat    = sat_quot(dvd_q, neg_q);
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    if (out_valid_q && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Working registers: quotient bits shift into dvd_q as dividend bits shift out.
   always_ff @(posedge ap_clk) begin
      case (state_q)
         IDLE: if (accept) begin
            dvd_q <= abs_in;
            rem_q <= '0;
            div_q <= divisor;
            neg_q <= dividend[DIVIDEND_W-1];
         end
         CALC: begin
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], qbit};
            rem_q <= rem_d;
         end
         FIX: begin
            dbz_fix_q <= (div_q == '0);
            if (div_q == '0) begin
               q_fix_q   <= neg_q ? QMIN : QMAX;
               r_fix_q   <= '0;
               ovf_fix_q <= 1'b0;
            end else begin
               q_fix_q   <= sat[QUOT_W-1:0];
               r_fix_q   <= sign_rem(rem_q, neg_q);
               ovf_fix_q <= sat[QUOT_W];
            end
         end
         default: ;
      endcase
   end

   // Result outputs and out_valid change together, on the first DONE cycle only.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_out_q   <= '0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) cnt_q <= CNT_LAST;
            CALC: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  quot_q      <= q_fix_q;
                  rem_out_q   <= r_fix_q;
                  ovf_q       <= ovf_fix_q;
                  dbz_q       <= dbz_fix_q;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tc_div_29s_12ns_17s_seq.sv
// Bench for tc_div_29s_12ns_17s_seq: directed vector table, handshake/reset sequences,
// and random operands checked against a plain-arithmetic division model.
module tb_tc_div_29s_12ns_17s_seq;

   localparam int LAT = 31;

   logic               ap_clk = 1'b0;
   logic               ap_rst_n, in_valid, in_ready, out_valid, out_ready, ovf, dbz;
   logic signed [28:0] dividend;
   logic [11:0]        divisor;
   logic signed [16:0] quotient;
   logic signed [12:0] remainder;

   int checks = 0;
   int errors = 0;

   typedef struct {
      longint a;
      longint b;
      longint q;
      longint r;
      bit     o;
      bit     d;
   } vec_t;

   vec_t tbl[12];

   tc_div_29s_12ns_17s_seq dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .ovf(ovf), .dbz(dbz)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: truncating signed division with saturation to the 17-bit range.
   function automatic void model(input longint a, input longint b,
                                 output longint q, output longint r, output bit o, output bit d);
      o = 1'b0;
      d = 1'b0;
      if (b == 0) begin
         d = 1'b1;
         r = 0;
         q = (a >= 0) ? 65535 : -65536;
      end else begin
         q = a / b;
         r = a % b;
         if (q > 65535) begin
            q = 65535;
            o = 1'b1;
         end else if (q < -65536) begin
            q = -65536;
            o = 1'b1;
         end
      end
   endfunction

   // One full transaction; waited reports how many cycles passed before in_ready was seen.
   task automatic run_op(input string tag, input longint a, input longint b, input int hold,
                         input longint eq, input longint er, input bit eo, input bit ed,
                         output int waited);
      int n;
      bit busy_bad, chg_bad, hold_bad;
      logic [31:0] snap, res;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 200) begin
         @(negedge ap_clk);
         waited++;
      end
      chk({tag, "_ready"}, in_ready, 1);
      dividend  = 29'(a);
      divisor   = 12'(b);
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      snap = {quotient, remainder, ovf, dbz};
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
      dividend = 29'($urandom);
      divisor  = 12'($urandom);
      busy_bad = 0;
      chg_bad  = 0;
      n = 0;
      while (n < 60) begin
         @(posedge ap_clk);
         #1;
         n++;
         if (out_valid === 1'b1) break;
         if (in_ready !== 1'b0) busy_bad = 1;
         if ({quotient, remainder, ovf, dbz} !== snap) chg_bad = 1;
         if (n == 3) begin
            in_valid = 1'b1;
         end
         if (n == 4) in_valid = 1'b0;
      end
      chk({tag, "_latency"}, n, LAT);
      chk({tag, "_busy_in_ready"}, busy_bad, 0);
      chk({tag, "_outputs_held_before_done"}, chg_bad, 0);
      chk({tag, "_quotient"}, quotient, eq);
      chk({tag, "_remainder"}, remainder, er);
      chk({tag, "_ovf"}, ovf, eo);
      chk({tag, "_dbz"}, dbz, ed);
      res = {quotient, remainder, ovf, dbz};
      hold_bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge ap_clk);
         #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {quotient, remainder, ovf, dbz} !== res)
            hold_bad = 1;
      end
      if (hold > 0) chk({tag, "_hold_stable"}, hold_bad, 0);
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      chk({tag, "_released_valid"}, out_valid, 0);
      chk({tag, "_released_ready"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      longint q, r;
      bit o, d;
      int w;
      bit seen;
      logic signed [28:0] t;

      tbl[0]  = '{1000, 7, 142, 6, 0, 0};
      tbl[1]  = '{-1000, 7, -142, -6, 0, 0};
      tbl[2]  = '{-65536, 1, -65536, 0, 0, 0};
      tbl[3]  = '{268435455, 1, 65535, 0, 1, 0};
      tbl[4]  = '{-268435456, 4095, -65536, -16, 1, 0};
      tbl[5]  = '{12345, 0, 65535, 0, 0, 1};
      tbl[6]  = '{-5, 0, -65536, 0, 0, 1};
      tbl[7]  = '{65535, 1, 65535, 0, 0, 0};
      tbl[8]  = '{65536, 1, 65535, 0, 1, 0};
      tbl[9]  = '{-65537, 1, -65536, 0, 1, 0};
      tbl[10] = '{5, 4095, 0, 5, 0, 0};
      tbl[11] = '{-268435456, 0, -65536, 0, 0, 1};

      ap_rst_n  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_ovf_dbz", {ovf, dbz}, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("rst_release_in_ready", in_ready, 1);

      foreach (tbl[i]) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, 0,
                tbl[i].q, tbl[i].r, tbl[i].o, tbl[i].d, w);
      end

      // Back-pressure for 10 cycles, then an immediately following operation.
      run_op("stall", 1000, 7, 10, 142, 6, 0, 0, w);
      run_op("b2b", -1000, 7, 0, -142, -6, 0, 0, w);
      chk("b2b_accept_wait", w, 0);

      // Reset in the middle of CALC: the abandoned result must never appear.
      @(negedge ap_clk);
      dividend = 29'sd1000;
      divisor  = 12'd7;
      in_valid = 1'b1;
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
      repeat (15) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(posedge ap_clk);
      #1;
      chk("midrst_valid_low", out_valid, 0);
      chk("midrst_ready_low", in_ready, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("midrst_ready_after", in_ready, 1);
      seen = 0;
      repeat (40) begin
         @(posedge ap_clk);
         #1;
         if (out_valid !== 1'b0) seen = 1;
      end
      chk("midrst_no_result", seen, 0);
      run_op("post_rst", 1000, 7, 0, 142, 6, 0, 0, w);

      for (int k = 0; k < 40; k++) begin
         longint a, b;
         t = 29'($urandom);
         t = t >>> $urandom_range(0, 28);
         a = t;
         b = $urandom_range(0, 4095) >> $urandom_range(0, 11);
         model(a, b, q, r, o, d);
         run_op($sformatf("rnd%0d", k), a, b, $urandom_range(0, 2), q, r, o, d, w);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
